ram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port 32x8 search RAM among N_REQ clients: the binary-search engine, the RAM loader and the display scanner.
- Sits between the clients and the RAM port and sequences one access per cycle.
- Supports locked bursts so the search engine can probe consecutive midpoints without losing the port.
- Routes read data back to the issuing client with a fixed-latency valid.

---
 rtl/ram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port search RAM among N_REQ clients (0 = loader,
// 1 = search engine, 2 = display scanner). One access is placed on the RAM
// port per cycle. Clients are picked round-robin. A client asserting Lock
// may keep the port for up to MAX_BURST back-to-back grants. Read data is
// handed back to the issuing client with a fixed-latency valid strobe.
//
// Ports
//   Clock, Resetn      clock and synchronous active-low reset
//   Req/Lock/Wr        per-client request, burst request and write flag
//   Addr/Wdata         per-client address / write data, packed by client index
//   Ram_Q              RAM read data
//   Gnt                one-hot; client's access is on the RAM port this cycle
//   Ram_Addr/Ram_Wdata registered RAM address / write data
//   Ram_Wren           registered RAM write enable
//   Rd_Valid           one-hot; Rd_Data belongs to this client this cycle
//   Rd_Data            pass-through of Ram_Q
module ram_port_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ-1:0]          Lock,
    input  logic [N_REQ-1:0]          Wr,
    input  logic [N_REQ*ADDR_W-1:0]   Addr,
    input  logic [N_REQ*DATA_W-1:0]   Wdata,
    input  logic [DATA_W-1:0]         Ram_Q,
    output logic [N_REQ-1:0]          Gnt,
    output logic [ADDR_W-1:0]         Ram_Addr,
    output logic [DATA_W-1:0]         Ram_Wdata,
    output logic                      Ram_Wren,
    output logic [N_REQ-1:0]          Rd_Valid,
    output logic [DATA_W-1:0]         Rd_Data
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;      // last winner; also the client granted while in GRANT
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_wren_q, ram_wren_d;

    // Read tag pipeline: stage 0 is loaded at the edge that ends a read's
    // grant cycle, so the last stage lines up with the RAM output.
    logic                tag_vld_q [RD_LAT];
    logic                tag_vld_d [RD_LAT];
    logic [IDX_W-1:0]    tag_id_q  [RD_LAT];
    logic [IDX_W-1:0]    tag_id_d  [RD_LAT];

    logic [ADDR_W-1:0]   addr_arr  [N_REQ];
    logic [DATA_W-1:0]   wdata_arr [N_REQ];
    logic [N_REQ-1:0]    elig;
    logic                lock_cont;
    logic                rr_found;
    logic [IDX_W-1:0]    rr_win;
    logic [IDX_W-1:0]    rr_cand;
    logic [IDX_W-1:0]    sel;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_client
            assign addr_arr[gi]  = Addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = Wdata[gi*DATA_W +: DATA_W];
            // The client holding the port is excluded; a locked continuation
            // is handled separately by lock_cont.
            assign elig[gi]      = Req[gi] &&
                                   !((state_q == GRANT) && (last_q == IDX_W'(gi)));
            assign Gnt[gi]       = (state_q == GRANT) && (last_q == IDX_W'(gi));
            assign Rd_Valid[gi]  = tag_vld_q[RD_LAT-1] &&
                                   (tag_id_q[RD_LAT-1] == IDX_W'(gi));
        end
    endgenerate

    assign lock_cont = (state_q == GRANT) && Req[last_q] && Lock[last_q] &&
                       (burst_q < BURST_W'(MAX_BURST - 1));

    // Round-robin scan starting just after the last winner.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = last_q;
        rr_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_cand = IDX_W'((int'(last_q) + k) % N_REQ);
            if (!rr_found && elig[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
        end
    end

    // Next-state and RAM port register inputs.
    always_comb begin
        state_d     = IDLE;
        last_d      = last_q;
        burst_d     = burst_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wren_d  = 1'b0;
        sel         = rr_win;

        if (lock_cont) begin
            state_d = GRANT;
            sel     = last_q;
            burst_d = burst_q + 1'b1;
        end else if (rr_found) begin
            state_d = GRANT;
            sel     = rr_win;
            burst_d = '0;
        end

        if (state_d == GRANT) begin
            last_d      = sel;
            ram_addr_d  = addr_arr[sel];
            ram_wdata_d = wdata_arr[sel];
            ram_wren_d  = Wr[sel];
        end
    end

    always_comb begin
        tag_vld_d[0] = (state_q == GRANT) && !ram_wren_q;
        tag_id_d[0]  = last_q;
        for (int s = 1; s < RD_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(N_REQ - 1);
            burst_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_d[s];
                tag_id_q[s]  <= tag_id_d[s];
            end
        end
    end

    assign Ram_Addr  = ram_addr_q;
    assign Ram_Wdata = ram_wdata_q;
    assign Ram_Wren  = ram_wren_q;
    assign Rd_Data   = Ram_Q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: a behavioural 32x8 RAM with one-cycle
// registered read, directed stimulus, and scoreboards for grants and
// read returns checked by a negedge monitor.
module tb_ram_port_arbiter;

    logic        Clock;
    logic        Resetn;
    logic [2:0]  Req, Lock, Wr;
    logic [14:0] Addr;
    logic [23:0] Wdata;
    logic [7:0]  Ram_Q;
    logic [2:0]  Gnt;
    logic [4:0]  Ram_Addr;
    logic [7:0]  Ram_Wdata;
    logic        Ram_Wren;
    logic [2:0]  Rd_Valid;
    logic [7:0]  Rd_Data;

    ram_port_arbiter #(
        .N_REQ(3), .ADDR_W(5), .DATA_W(8), .RD_LAT(1), .MAX_BURST(4)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Req(Req), .Lock(Lock), .Wr(Wr),
        .Addr(Addr), .Wdata(Wdata), .Ram_Q(Ram_Q), .Gnt(Gnt),
        .Ram_Addr(Ram_Addr), .Ram_Wdata(Ram_Wdata), .Ram_Wren(Ram_Wren),
        .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural RAM: unwritten words hold a fixed address-derived pattern.
    function automatic logic [7:0] ram_init(input logic [4:0] a);
        return {a, 3'b000} ^ 8'h0A;
    endfunction

    logic [7:0] ram_mem [32];
    bit   [31:0] ram_written = '0;
    always @(posedge Clock) begin
        Ram_Q <= ram_written[Ram_Addr] ? ram_mem[Ram_Addr] : ram_init(Ram_Addr);
        if (Ram_Wren) begin
            ram_mem[Ram_Addr]     <= Ram_Wdata;
            ram_written[Ram_Addr] <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
        logic [4:0] addr;
        logic       wren;
        logic [7:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int         cyc;
        logic [2:0] vld;
        logic [7:0] data;
    } rd_exp_t;

    gnt_exp_t gnt_sb [$];
    rd_exp_t  rd_sb  [$];

    // Push an expected grant in cycle c; a read also expects its data in c+1.
    task automatic expect_gnt(input int c, input int client, input logic [4:0] a,
                              input logic w, input logic [7:0] wd,
                              input logic [7:0] rdata, input bit with_rd);
        gnt_exp_t g;
        rd_exp_t  r;
        g.cyc = c; g.gnt = 3'(1 << client); g.addr = a; g.wren = w; g.wdata = wd;
        gnt_sb.push_back(g);
        if (!w && with_rd) begin
            r.cyc = c + 1; r.vld = 3'(1 << client); r.data = rdata;
            rd_sb.push_back(r);
        end
    endtask

    task automatic set_client(input int i, input logic [4:0] a, input logic w,
                              input logic [7:0] d);
        Addr[i*5 +: 5]  = a;
        Wr[i]           = w;
        Wdata[i*8 +: 8] = d;
    endtask

    // Monitor: every grant and every read return is popped and compared.
    always @(negedge Clock) begin : monitor
        gnt_exp_t g;
        rd_exp_t  r;
        if (Gnt != 3'b000) begin
            $display("cyc=%0d gnt=%b addr=%0d wren=%b wdata=%h", cyc, Gnt, Ram_Addr, Ram_Wren, Ram_Wdata);
            if (gnt_sb.size() == 0) begin
                check("gnt_unexpected", 32'(Gnt), 32'd0);
            end else begin
                g = gnt_sb.pop_front();
                check("gnt_cycle", cyc, g.cyc);
                check("gnt", 32'(Gnt), 32'(g.gnt));
                check("ram_addr", 32'(Ram_Addr), 32'(g.addr));
                check("ram_wren", 32'(Ram_Wren), 32'(g.wren));
                if (g.wren) check("ram_wdata", 32'(Ram_Wdata), 32'(g.wdata));
            end
        end
        if (Rd_Valid != 3'b000) begin
            $display("cyc=%0d rd_valid=%b rd_data=%h", cyc, Rd_Valid, Rd_Data);
            if (rd_sb.size() == 0) begin
                check("rd_unexpected", 32'(Rd_Valid), 32'd0);
            end else begin
                r = rd_sb.pop_front();
                check("rd_cycle", cyc, r.cyc);
                check("rd_valid", 32'(Rd_Valid), 32'(r.vld));
                check("rd_data", 32'(Rd_Data), 32'(r.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        Resetn = 1'b0;
        Req    = 3'b111;
        Lock   = 3'b000;
        Wr     = 3'b000;
        Addr   = '0;
        Wdata  = '0;
        set_client(0, 5'd3, 1'b0, 8'h00);
        set_client(1, 5'd9, 1'b0, 8'h00);
        set_client(2, 5'd20, 1'b0, 8'h00);

        // Reset held two edges with all clients requesting.
        repeat (2) @(negedge Clock);
        check("rst_gnt", 32'(Gnt), 32'd0);
        check("rst_wren", 32'(Ram_Wren), 32'd0);
        check("rst_addr", 32'(Ram_Addr), 32'd0);
        check("rst_wdata", 32'(Ram_Wdata), 32'd0);
        check("rst_rdvalid", 32'(Rd_Valid), 32'd0);

        // Release: rotation 0,1,2,0,1,2 with no idle cycles.
        c = cyc;
        Resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0: expect_gnt(c + 1 + k, 0, 5'd3,  1'b0, 8'h00, ram_init(5'd3),  1'b1);
                1: expect_gnt(c + 1 + k, 1, 5'd9,  1'b0, 8'h00, 8'h42,           1'b1);
                default: expect_gnt(c + 1 + k, 2, 5'd20, 1'b0, 8'h00, ram_init(5'd20), 1'b1);
            endcase
        end
        repeat (6) @(negedge Clock);
        Req = 3'b000;
        repeat (3) @(negedge Clock);

        // Single read from the search client.
        c = cyc;
        set_client(1, 5'd9, 1'b0, 8'h00);
        Req = 3'b010;
        expect_gnt(c + 1, 1, 5'd9, 1'b0, 8'h00, 8'h42, 1'b1);
        @(negedge Clock);
        Req = 3'b000;
        repeat (3) @(negedge Clock);

        // Locked burst by client 2 with Last=1.
        c = cyc;
        set_client(0, 5'd4, 1'b0, 8'h00);
        set_client(2, 5'd20, 1'b0, 8'h00);
        Lock = 3'b100;
        Req  = 3'b111;
        for (int k = 1; k <= 4; k++)
            expect_gnt(c + k, 2, 5'd20, 1'b0, 8'h00, ram_init(5'd20), 1'b1);
        expect_gnt(c + 5, 0, 5'd4,  1'b0, 8'h00, ram_init(5'd4),  1'b1);
        expect_gnt(c + 6, 1, 5'd9,  1'b0, 8'h00, 8'h42,           1'b1);
        expect_gnt(c + 7, 2, 5'd20, 1'b0, 8'h00, ram_init(5'd20), 1'b1);
        repeat (7) @(negedge Clock);
        Req  = 3'b000;
        Lock = 3'b000;
        repeat (3) @(negedge Clock);

        // Single write from the loader to the top address.
        c = cyc;
        set_client(0, 5'd31, 1'b1, 8'hA5);
        Req = 3'b001;
        expect_gnt(c + 1, 0, 5'd31, 1'b1, 8'hA5, 8'h00, 1'b0);
        @(negedge Clock);
        Req = 3'b000;
        Wr  = 3'b000;
        @(negedge Clock);
        check("idle_wren", 32'(Ram_Wren), 32'd0);
        check("idle_addr_hold", 32'(Ram_Addr), 32'd31);
        check("idle_wdata_hold", 32'(Ram_Wdata), 32'hA5);
        @(negedge Clock);
        check("idle_wren2", 32'(Ram_Wren), 32'd0);

        // Interleaved write (client 0) and reads (client 1); Last=0.
        c = cyc;
        set_client(0, 5'd7, 1'b1, 8'h3C);
        set_client(1, 5'd31, 1'b0, 8'h00);
        Req = 3'b011;
        expect_gnt(c + 1, 1, 5'd31, 1'b0, 8'h00, 8'hA5, 1'b1);
        expect_gnt(c + 2, 0, 5'd7,  1'b1, 8'h3C, 8'h00, 1'b0);
        expect_gnt(c + 3, 1, 5'd31, 1'b0, 8'h00, 8'hA5, 1'b1);
        repeat (3) @(negedge Clock);
        Req = 3'b000;
        Wr  = 3'b000;
        repeat (3) @(negedge Clock);

        // Reset right after a read grant discards its return.
        c = cyc;
        set_client(2, 5'd7, 1'b0, 8'h00);
        Req = 3'b100;
        expect_gnt(c + 1, 2, 5'd7, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge Clock);
        Req    = 3'b000;
        Resetn = 1'b0;
        @(negedge Clock);
        check("mid_rst_rdvalid", 32'(Rd_Valid), 32'd0);
        check("mid_rst_gnt", 32'(Gnt), 32'd0);
        check("mid_rst_addr", 32'(Ram_Addr), 32'd0);
        check("mid_rst_wren", 32'(Ram_Wren), 32'd0);
        check("mid_rst_wdata", 32'(Ram_Wdata), 32'd0);

        // After reset the pointer restarts at client 0's priority slot.
        c = cyc;
        Resetn = 1'b1;
        set_client(1, 5'd7, 1'b0, 8'h00);
        set_client(2, 5'd20, 1'b0, 8'h00);
        Req = 3'b110;
        expect_gnt(c + 1, 1, 5'd7,  1'b0, 8'h00, 8'h3C,           1'b1);
        expect_gnt(c + 2, 2, 5'd20, 1'b0, 8'h00, ram_init(5'd20), 1'b1);
        repeat (2) @(negedge Clock);
        Req = 3'b000;
        repeat (4) @(negedge Clock);

        check("gnt_sb_empty", 32'(gnt_sb.size()), 32'd0);
        check("rd_sb_empty", 32'(rd_sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
